day_5_range_engine: RTL and testbench

DAY_5_RANGE_ENGINE -- requirements
Module: day_5_range_engine

---
 rtl/day_5_range_engine.sv | 135 +++++++++++++
 tb/tb_day_5_range_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/day_5_range_engine.sv
// day_5_range_engine: range table that counts IDs covered by any range, or sizes the union of all ranges
module day_5_range_engine #(
    parameter int WIDTH      = 50,
    parameter int MAX_RANGES = 256,
    parameter int RES_W      = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             rng_valid,
    input  logic [WIDTH-1:0] rng_lo,
    input  logic [WIDTH-1:0] rng_hi,
    input  logic             rng_last,
    output logic             rng_ready,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_data,
    input  logic             id_last,
    output logic             id_ready,
    output logic             busy,
    output logic             finished,
    output logic [RES_W-1:0] result,
    output logic             overflow
);
    localparam int AW = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1;
    localparam int CW = $clog2(MAX_RANGES + 1);
    localparam int XW = WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(MAX_RANGES);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, SWEEP, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0] lo_tab [MAX_RANGES];
    logic [WIDTH-1:0] hi_tab [MAX_RANGES];
    logic [MAX_RANGES-1:0] vld, prc, hits;
    logic [CW-1:0] cnt, idx;
    logic [AW-1:0] ia, wa, best_idx;
    logic [WIDTH-1:0] best_lo, best_hi, cur_lo, cur_hi;
    logic [RES_W-1:0] sum, seg_len;
    logic mode_q, found, seg_open, start_ok, rng_acc, id_acc, sweep_end, disjoint;

    assign rng_ready = state == LOAD;
    assign id_ready  = state == CHECK;
    assign busy      = state == LOAD || state == CHECK || state == SWEEP;
    assign finished  = state == DONE;
    assign result    = finished ? sum : '0;
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign rng_acc   = rng_valid && rng_ready;
    assign id_acc    = id_valid && id_ready;
    assign ia        = idx[AW-1:0];
    assign wa        = cnt[AW-1:0];
    assign best_hi   = hi_tab[best_idx];
    assign seg_len   = RES_W'(cur_hi) - RES_W'(cur_lo) + RES_W'(1);
    // widened so an all-ones cur_hi does not wrap and fake a gap
    assign disjoint  = XW'(best_lo) > XW'(cur_hi) + XW'(1);
    assign sweep_end = state == SWEEP && idx >= cnt && !found;

    always_comb begin
        hits = '0;
        for (int i = 0; i < MAX_RANGES; i++)
            hits[i] = vld[i] && lo_tab[i] <= id_data && id_data <= hi_tab[i];
    end

    always_comb begin
        state_n = state;
        if (start_ok)
            state_n = LOAD;
        else if (rng_acc && rng_last)
            state_n = mode_q ? SWEEP : CHECK;
        else if ((id_acc && id_last) || sweep_end)
            state_n = DONE;
    end

    always_ff @(posedge clk)
        if (rst)
            state <= IDLE;
        else
            state <= state_n;

    always_ff @(posedge clk)
        if (rng_acc && cnt < FULL) begin
            lo_tab[wa] <= rng_lo;
            hi_tab[wa] <= rng_hi;
        end

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sum      <= '0;
            overflow <= 1'b0;
            vld      <= '0;
            prc      <= '0;
            cnt      <= '0;
            idx      <= '0;
            found    <= 1'b0;
            seg_open <= 1'b0;
            mode_q   <= rst ? 1'b0 : mode;
        end else begin
            if (rng_acc) begin
                if (cnt < FULL) begin
                    vld[wa] <= (rng_lo <= rng_hi);
                    cnt     <= cnt + CW'(1);
                end else
                    overflow <= 1'b1;
            end
            if (id_acc && |hits)
                sum <= sum + RES_W'(1);
            if (state == SWEEP) begin
                // scan one entry per cycle, then consume the lowest-lo candidate
                if (idx < cnt) begin
                    if (vld[ia] && !prc[ia] && (!found || lo_tab[ia] < best_lo)) begin
                        found    <= 1'b1;
                        best_idx <= ia;
                        best_lo  <= lo_tab[ia];
                    end
                    idx <= idx + CW'(1);
                end else if (found) begin
                    prc[best_idx] <= 1'b1;
                    found         <= 1'b0;
                    idx           <= '0;
                    seg_open      <= 1'b1;
                    if (!seg_open || disjoint) begin
                        cur_lo <= best_lo;
                        cur_hi <= best_hi;
                        if (seg_open)
                            sum <= sum + seg_len;
                    end else if (best_hi > cur_hi)
                        cur_hi <= best_hi;
                end else if (seg_open) begin
                    sum      <= sum + seg_len;
                    seg_open <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_day_5_range_engine.sv
// tb_day_5_range_engine: table-driven jobs scored against a queue on a full-size and a 4-entry engine
module tb_day_5_range_engine;
    localparam int W  = 50;
    localparam int RW = W + 1;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          ovf;
    } exp_t;

    typedef struct {
        bit              mode;
        int              nr;
        logic [0:5][W-1:0] lo;
        logic [0:5][W-1:0] hi;
        int              ni;
        logic [0:5][W-1:0] ids;
        logic [RW-1:0]   res;
        bit              ovf0;
        bit              ovf1;
        bit              gaps;
        bit              poke;
        bit              lat;
    } job_t;

    logic clk = 1'b0;
    logic rst, start, mode, rng_valid, rng_last, id_valid, id_last;
    logic [W-1:0] rng_lo, rng_hi, id_data;
    logic rng_ready0, id_ready0, busy0, finished0, overflow0;
    logic rng_ready1, id_ready1, busy1, finished1, overflow1;
    logic [RW-1:0] result0, result1;

    int checks = 0, errors = 0, cyc = 0, t_last = 0;
    bit lat_chk = 1'b0;
    logic fin0_d = 1'b0, fin1_d = 1'b0;
    exp_t q0[$], q1[$];
    job_t jt[11];
    job_t rj;

    day_5_range_engine #(.WIDTH(W)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rng_valid(rng_valid), .rng_lo(rng_lo), .rng_hi(rng_hi), .rng_last(rng_last), .rng_ready(rng_ready0),
        .id_valid(id_valid), .id_data(id_data), .id_last(id_last), .id_ready(id_ready0),
        .busy(busy0), .finished(finished0), .result(result0), .overflow(overflow0)
    );

    day_5_range_engine #(.WIDTH(W), .MAX_RANGES(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rng_valid(rng_valid), .rng_lo(rng_lo), .rng_hi(rng_hi), .rng_last(rng_last), .rng_ready(rng_ready1),
        .id_valid(id_valid), .id_data(id_data), .id_last(id_last), .id_ready(id_ready1),
        .busy(busy1), .finished(finished1), .result(result1), .overflow(overflow1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] L(input longint v);
        return v[W-1:0];
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    function automatic logic [RW-1:0] model(input job_t j);
        int n;
        bit h;
        bit [63:0] cov;
        n = 0;
        cov = '0;
        if (!j.mode) begin
            for (int i = 0; i < j.ni; i++) begin
                h = 1'b0;
                for (int r = 0; r < j.nr; r++)
                    if (j.lo[r] <= j.ids[i] && j.ids[i] <= j.hi[r]) h = 1'b1;
                n += int'(h);
            end
        end else begin
            for (int r = 0; r < j.nr; r++)
                for (longint v = longint'(j.lo[r]); v <= longint'(j.hi[r]); v++) cov[v] = 1'b1;
            n = $countones(cov);
        end
        return RW'(n);
    endfunction

    function automatic job_t rand_job();
        job_t j;
        j.mode = 1'($urandom_range(0, 1));
        j.nr = int'($urandom_range(1, 4));
        j.ni = int'($urandom_range(1, 6));
        j.lo = '0;
        j.hi = '0;
        j.ids = '0;
        for (int r = 0; r < j.nr; r++) begin
            j.lo[r] = L(longint'($urandom_range(0, 63)));
            j.hi[r] = L(longint'($urandom_range(0, 63)));
        end
        for (int i = 0; i < j.ni; i++) j.ids[i] = L(longint'($urandom_range(0, 70)));
        j.ovf0 = 1'b0;
        j.ovf1 = 1'b0;
        j.gaps = 1'b1;
        j.poke = 1'b0;
        j.lat = 1'b0;
        j.res = model(j);
        return j;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_finished0"}, finished0, 0);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_result0"}, result0, 0);
        chk({tag, "_overflow0"}, overflow0, 0);
        chk({tag, "_rng_ready0"}, rng_ready0, 0);
        chk({tag, "_id_ready0"}, id_ready0, 0);
        chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_result1"}, result1, 0);
    endtask

    task automatic send_rng(input logic [W-1:0] lo, input logic [W-1:0] hi, input bit last, input bit gaps);
        int g;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        rng_lo = lo;
        rng_hi = hi;
        rng_last = last;
        rng_valid = 1'b1;
        g = 0;
        while (!rng_ready0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("rng_ready_in_load", rng_ready0, 1);
        @(negedge clk);
        if (last) t_last = cyc;
        rng_valid = 1'b0;
        rng_last = 1'b0;
    endtask

    task automatic send_id(input logic [W-1:0] id, input bit last, input bit gaps);
        int g;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        id_data = id;
        id_last = last;
        id_valid = 1'b1;
        g = 0;
        while (!id_ready0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("id_ready_in_check", id_ready0, 1);
        @(negedge clk);
        id_valid = 1'b0;
        id_last = 1'b0;
    endtask

    task automatic run_job(input job_t j, input int abort_at);
        int g;
        g = 0;
        while ((busy0 || busy1) && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("idle_before_start", busy0 | busy1, 0);
        if (abort_at < 0) begin
            q0.push_back('{res: j.res, ovf: j.ovf0});
            q1.push_back('{res: j.res, ovf: j.ovf1});
            lat_chk = j.lat;
        end
        mode = j.mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < j.nr; r++) begin
            start = j.poke && r == 1;
            send_rng(j.lo[r], j.hi[r], r == j.nr - 1, j.gaps);
            start = 1'b0;
        end
        if (!j.mode)
            for (int i = 0; i < j.ni; i++) begin
                if (i == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_zero("abort");
                    rst = 1'b0;
                    return;
                end
                send_id(j.ids[i], i == j.ni - 1, j.gaps);
            end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (finished0 && !fin0_d) begin
            if (q0.size() == 0)
                chk("unexpected_finish0", 1, 0);
            else begin
                e = q0.pop_front();
                chk("result0", result0, e.res);
                chk("overflow0", overflow0, e.ovf);
                if (lat_chk) chk("sweep_latency_le_30", (cyc - t_last) <= 30, 1);
            end
        end
        if (finished1 && !fin1_d) begin
            if (q1.size() == 0)
                chk("unexpected_finish1", 1, 0);
            else begin
                e = q1.pop_front();
                chk("result1", result1, e.res);
                chk("overflow1", overflow1, e.ovf);
            end
        end
        fin0_d <= finished0;
        fin1_d <= finished1;
    end

    initial begin
        int g;
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        rng_valid = 1'b0;
        rng_last = 1'b0;
        rng_lo = '0;
        rng_hi = '0;
        id_valid = 1'b0;
        id_last = 1'b0;
        id_data = '0;
        //        mode nr  lo                                       hi                                       ni ids                                          res         ovf0 ovf1 gaps poke lat
        jt[0]  = '{1'b0, 4, {L(3), L(10), L(16), L(12), L(0), L(0)}, {L(5), L(14), L(20), L(18), L(0), L(0)}, 6, {L(1), L(5), L(8), L(11), L(17), L(32)}, RW'(3), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        jt[1]  = '{1'b1, 4, {L(3), L(10), L(16), L(12), L(0), L(0)}, {L(5), L(14), L(20), L(18), L(0), L(0)}, 0, {6{L(0)}}, RW'(14), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        jt[2]  = '{1'b1, 3, {L(0), L(1), L(5), L(0), L(0), L(0)}, {L(0), L(1), L(4), L(0), L(0), L(0)}, 0, {6{L(0)}}, RW'(2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        jt[3]  = '{1'b1, 1, {6{L(0)}}, {L(-1), L(0), L(0), L(0), L(0), L(0)}, 0, {6{L(0)}}, RW'(1) << W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        jt[4]  = '{1'b1, 1, {L(7), L(0), L(0), L(0), L(0), L(0)}, {L(3), L(0), L(0), L(0), L(0), L(0)}, 0, {6{L(0)}}, RW'(0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        jt[5]  = '{1'b0, 1, {L(10), L(0), L(0), L(0), L(0), L(0)}, {L(20), L(0), L(0), L(0), L(0), L(0)}, 4, {L(9), L(10), L(20), L(21), L(0), L(0)}, RW'(2), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        jt[6]  = '{1'b1, 4, {L(50), L(1), L(200), L(101), L(0), L(0)}, {L(60), L(100), L(200), L(150), L(0), L(0)}, 0, {6{L(0)}}, RW'(151), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        jt[7]  = '{1'b1, 2, {L(5), L(5), L(0), L(0), L(0), L(0)}, {L(10), L(7), L(0), L(0), L(0), L(0)}, 0, {6{L(0)}}, RW'(6), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        jt[8]  = '{1'b1, 2, {L(-2), L(-1), L(0), L(0), L(0), L(0)}, {L(-1), L(-1), L(0), L(0), L(0), L(0)}, 0, {6{L(0)}}, RW'(2), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        jt[9]  = '{1'b0, 6, {6{L(0)}}, {6{L(9)}}, 1, {L(9), L(0), L(0), L(0), L(0), L(0)}, RW'(1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        jt[10] = '{1'b0, 1, {L(-2), L(0), L(0), L(0), L(0), L(0)}, {L(-1), L(0), L(0), L(0), L(0), L(0)}, 3, {L(-1), L(0), L(-3), L(0), L(0), L(0)}, RW'(1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 11; k++) run_job(jt[k], -1);
        run_job(jt[0], 3);
        run_job(jt[0], -1);
        for (int k = 0; k < 4; k++) begin
            rj = rand_job();
            run_job(rj, -1);
        end
        g = 0;
        while ((q0.size() != 0 || q1.size() != 0) && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);
        chk("done_holds_finished0", finished0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
